// File: rtl/ras_trace_checker.sv
// Golden return-address-stack checker fed from a trace FIFO read port.
// Define RAS_CHK_FIRSTERR_EN to capture index/expected/received of the first mismatch.
module ras_trace_checker #(
    parameter int STACK_DEPTH = 16,
    parameter int SP_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_pop,
    input  logic [35:0] fifo_dout,
    output logic        done,
    output logic        mismatch,
    output logic        underflow,
    output logic        overflow,
    output logic [31:0] rec_count,
    output logic [15:0] err_count,
    output logic [31:0] first_err_idx,
    output logic [31:0] first_err_exp,
    output logic [31:0] first_err_got
);
    localparam logic [1:0]    KIND_CALL  = 2'b00;
    localparam logic [1:0]    KIND_RET   = 2'b01;
    localparam logic [1:0]    KIND_FLUSH = 2'b10;
    localparam logic [SP_W:0] DEPTH_CNT  = (SP_W + 1)'(STACK_DEPTH);

    logic              rd_valid;
    logic [SP_W-1:0]   sp;
    logic [SP_W:0]     cnt;
    logic [31:0]       stack [STACK_DEPTH];
    logic [1:0]        kind;
    logic [31:0]       addr;
    logic [31:0]       top;
    logic              proc;
    logic              ret_hit;
    logic              miss;
    logic              unused_rsvd;

    assign kind        = fifo_dout[35:34];
    assign addr        = fifo_dout[31:0];
    assign unused_rsvd = ^fifo_dout[33:32];

    assign fifo_pop = enable & ~fifo_empty & ~done & ~rst;
    // A record popped while END is being processed arrives after done is set and is dropped.
    assign proc     = rd_valid & ~done;

    // Asynchronous read of the register array: a CALL written on the previous
    // edge is already visible, so back-to-back CALL/RET needs no bypass path.
    assign top     = stack[sp - 1'b1];
    assign ret_hit = proc && (kind == KIND_RET) && (cnt != '0);
    assign miss    = ret_hit && (addr != top);

    always_ff @(posedge clk) begin
        if (proc && kind == KIND_CALL) begin
            stack[sp] <= addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            sp        <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            rec_count <= '0;
            err_count <= '0;
        end else begin
            rd_valid <= fifo_pop;
            mismatch <= miss;
            if (miss && err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
            end
            if (proc) begin
                rec_count <= rec_count + 32'd1;
                case (kind)
                    KIND_CALL: begin
                        sp <= sp + 1'b1;
                        if (cnt != DEPTH_CNT) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    KIND_RET: begin
                        if (cnt != '0) begin
                            sp  <= sp - 1'b1;
                            cnt <= cnt - 1'b1;
                        end else begin
                            underflow <= 1'b1;
                        end
                    end
                    KIND_FLUSH: begin
                        sp  <= '0;
                        cnt <= '0;
                    end
                    default: done <= 1'b1;
                endcase
            end
        end
    end

`ifdef RAS_CHK_FIRSTERR_EN
    logic [31:0] fe_idx;
    logic [31:0] fe_exp;
    logic [31:0] fe_got;

    // err_count saturates and never wraps to zero, so zero means "no mismatch yet".
    always_ff @(posedge clk) begin
        if (rst) begin
            fe_idx <= '0;
            fe_exp <= '0;
            fe_got <= '0;
        end else if (miss && err_count == '0) begin
            fe_idx <= rec_count;
            fe_exp <= top;
            fe_got <= addr;
        end
    end

    assign first_err_idx = fe_idx;
    assign first_err_exp = fe_exp;
    assign first_err_got = fe_got;
`else
    assign first_err_idx = '0;
    assign first_err_exp = '0;
    assign first_err_got = '0;
`endif

endmodule

// File: tb/tb_ras_trace_checker.sv
// Bench for ras_trace_checker: behavioural FIFO + queue-based stack model,
// per-cycle output compare, directed scenarios and a randomized stream.
module tb_ras_trace_checker;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [35:0] fifo_dout = '0;
    logic        fifo_pop;
    logic        done, mismatch, underflow, overflow;
    logic [31:0] rec_count;
    logic [15:0] err_count;
    logic [31:0] first_err_idx, first_err_exp, first_err_got;

    ras_trace_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .fifo_dout(fifo_dout), .done(done),
        .mismatch(mismatch), .underflow(underflow), .overflow(overflow),
        .rec_count(rec_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
        .first_err_got(first_err_got)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int mis_seen = 0;

    logic [35:0] fq[$];

    // Model state: the return stack is a plain queue holding at most DEPTH entries.
    logic [31:0] m_stack[$];
    bit          m_done, m_under, m_over, m_mis, m_have;
    logic [31:0] m_rec, m_idx, m_exp, m_got;
    int          m_errc;
    bit          inf_v;
    logic [35:0] inf_rec;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_apply(input logic [35:0] r);
        logic [31:0] e;
        case (r[35:34])
            2'b00: begin
                m_stack.push_back(r[31:0]);
                if (m_stack.size() > DEPTH) begin
                    void'(m_stack.pop_front());
                    m_over = 1;
                end
            end
            2'b01: begin
                if (m_stack.size() == 0) m_under = 1;
                else begin
                    e = m_stack.pop_back();
                    if (e != r[31:0]) begin
                        m_mis = 1;
                        if (!m_have) begin
                            m_have = 1; m_idx = m_rec; m_exp = e; m_got = r[31:0];
                        end
                        if (m_errc < 65535) m_errc++;
                    end
                end
            end
            2'b10: m_stack.delete();
            default: m_done = 1;
        endcase
        m_rec = m_rec + 1;
    endtask

    // Upstream FIFO (registered empty flag) and model advance on each edge.
    always @(posedge clk) begin
        if (rst) begin
            m_stack.delete();
            m_done = 0; m_under = 0; m_over = 0; m_mis = 0; m_have = 0;
            m_rec = 0; m_idx = 0; m_exp = 0; m_got = 0; m_errc = 0;
            inf_v = 0;
            fq.delete();
            fifo_empty <= 1'b1;
        end else begin
            m_mis = 0;
            if (inf_v && !m_done) model_apply(inf_rec);
            inf_v = fifo_pop;
            if (fifo_pop) begin
                inf_rec = fq.pop_front();
                fifo_dout <= inf_rec;
            end
            fifo_empty <= (fq.size() == 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (mismatch === 1'b1) mis_seen++;
        cmp("fifo_pop", {31'd0, fifo_pop}, {31'd0, enable & ~fifo_empty & ~m_done & ~rst});
        cmp("done", {31'd0, done}, {31'd0, m_done});
        cmp("mismatch", {31'd0, mismatch}, {31'd0, m_mis});
        cmp("underflow", {31'd0, underflow}, {31'd0, m_under});
        cmp("overflow", {31'd0, overflow}, {31'd0, m_over});
        cmp("rec_count", rec_count, m_rec);
        cmp("err_count", {16'd0, err_count}, 32'(m_errc));
`ifdef RAS_CHK_FIRSTERR_EN
        cmp("first_err_idx", first_err_idx, m_idx);
        cmp("first_err_exp", first_err_exp, m_exp);
        cmp("first_err_got", first_err_got, m_got);
`else
        cmp("first_err_idx", first_err_idx, 32'd0);
        cmp("first_err_exp", first_err_exp, 32'd0);
        cmp("first_err_got", first_err_got, 32'd0);
`endif
    end

    function automatic logic [35:0] rec(input logic [1:0] kind, input logic [31:0] a);
        return {kind, 2'b00, a};
    endfunction

    task automatic push(input logic [1:0] kind, input logic [31:0] a);
        fq.push_back(rec(kind, a));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mis_seen = 0;
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fq.size() == 0 && !inf_v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout got=%0d exp=0 t=%0t", fq.size(), $time);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] gs[$];
        bit          found;

        // Balanced calls/returns.
        do_reset();
        enable = 1'b1;
        push(2'b00, 32'h100); push(2'b00, 32'h200);
        push(2'b01, 32'h200); push(2'b01, 32'h100); push(2'b11, 32'h0);
        drain(100);
        cmp("t1_err", {16'd0, err_count}, 32'd0);
        cmp("t1_rec", rec_count, 32'd5);
        cmp("t1_done", {31'd0, done}, 32'd1);
        cmp("t1_pulses", 32'(mis_seen), 32'd0);

        // Single miscompare.
        do_reset();
        enable = 1'b1;
        push(2'b00, 32'h100); push(2'b01, 32'h104); push(2'b11, 32'h0);
        drain(100);
        cmp("t2_pulses", 32'(mis_seen), 32'd1);
        cmp("t2_err", {16'd0, err_count}, 32'd1);
`ifdef RAS_CHK_FIRSTERR_EN
        cmp("t2_idx", first_err_idx, 32'd1);
        cmp("t2_exp", first_err_exp, 32'h100);
        cmp("t2_got", first_err_got, 32'h104);
`endif

        // Overflow wraps the oldest entry; returns 16..1 still match.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i <= 16; i++) push(2'b00, 32'(i));
        for (int i = 16; i >= 1; i--) push(2'b01, 32'(i));
        push(2'b11, 32'h0);
        drain(200);
        cmp("t3_over", {31'd0, overflow}, 32'd1);
        cmp("t3_under", {31'd0, underflow}, 32'd0);
        cmp("t3_err", {16'd0, err_count}, 32'd0);
        cmp("t3_rec", rec_count, 32'd34);

        // Underflow and flush.
        do_reset();
        enable = 1'b1;
        push(2'b01, 32'h40); push(2'b00, 32'h8); push(2'b10, 32'h0); push(2'b01, 32'h8);
        drain(100);
        cmp("t4_under", {31'd0, underflow}, 32'd1);
        cmp("t4_err", {16'd0, err_count}, 32'd0);
        cmp("t4_rec", rec_count, 32'd4);
        cmp("t4_done", {31'd0, done}, 32'd0);

        // Record popped behind END is discarded.
        do_reset();
        push(2'b11, 32'h0); push(2'b00, 32'h5);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        drain(100);
        cmp("t5_done", {31'd0, done}, 32'd1);
        cmp("t5_rec", rec_count, 32'd1);
        cmp("t5_over", {31'd0, overflow}, 32'd0);

        // Reset while the third CALL is in flight.
        do_reset();
        push(2'b00, 32'h11); push(2'b00, 32'h22); push(2'b00, 32'h33);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (fq.size() == 0 && inf_v) begin
                found = 1;
                break;
            end
        end
        cmp("t6_inflight", {31'd0, found}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp("t6_rec0", rec_count, 32'd0);
        cmp("t6_done0", {31'd0, done}, 32'd0);
        cmp("t6_flags0", {29'd0, mismatch, underflow, overflow}, 32'd0);
        rst = 1'b0;
        push(2'b01, 32'h1); push(2'b11, 32'h0);
        drain(100);
        cmp("t6_under", {31'd0, underflow}, 32'd1);
        cmp("t6_rec", rec_count, 32'd2);
        cmp("t6_err", {16'd0, err_count}, 32'd0);

        // Randomized stream with gaps, enable toggling and mostly-correct returns.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: begin
                        a = $urandom;
                        push(2'b00, a);
                        gs.push_back(a);
                        if (gs.size() > DEPTH) void'(gs.pop_front());
                    end
                    5, 6, 7, 8: begin
                        a = $urandom;
                        if (gs.size() != 0) begin
                            if ($urandom_range(0, 4) != 0) a = gs.pop_back();
                            else void'(gs.pop_back());
                        end
                        push(2'b01, a);
                    end
                    default: begin
                        push(2'b10, 32'h0);
                        gs.delete();
                    end
                endcase
            end
        end
        push(2'b11, 32'h0);
        enable = 1'b1;
        drain(2000);
        cmp("rand_done", {31'd0, done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        n_err++;
        $display("FAIL watchdog got=running exp=finished t=%0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
